fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_pc_gen.sv | 22 ++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// bubble instruction and PC width.
package fetch_pkg;

  localparam int PC_W = 32;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// Combinational next-PC selection: redirect target, sequential +4, or hold.
module fetch_pc_gen
  import fetch_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic            advance,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] next_pc
);

  always_comb begin
    next_pc = pc;
    // Redirect targets are word-aligned by dropping the low bits.
    if (redirect) begin
      next_pc = {redirect_pc[PC_W-1:2], 2'b00};
    end else if (advance) begin
      next_pc = pc + PC_W'(4);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, stall and
// redirect handling, sticky misaligned-target flag and fetch counter.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  import fetch_pkg::*;

  localparam logic [PC_W-1:0] RESET_PC_ALIGNED = {RESET_PC[PC_W-1:2], 2'b00};

  state_e          state_reg;
  state_e          state_next;
  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] pc_next;
  logic [31:0]     instr_reg;
  logic [PC_W-1:0] id_pc_reg;
  logic            valid_reg;
  logic            misalign_reg;
  logic [31:0]     count_reg;
  logic            advance;

  // The IDLE cycle after reset never fetches; redirect outranks stall.
  assign advance    = (state_reg != IDLE) && !stall && !redirect;
  assign state_next = (stall && !redirect) ? STALL : FETCH;

  fetch_pc_gen u_pc_gen (
    .pc          (pc_reg),
    .advance     (advance),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .next_pc     (pc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC_ALIGNED;
      instr_reg    <= NOP_INSTR;
      id_pc_reg    <= '0;
      valid_reg    <= 1'b0;
      misalign_reg <= 1'b0;
      count_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (redirect && (redirect_pc[1:0] != 2'b00)) begin
        misalign_reg <= 1'b1;
      end
      if (redirect) begin
        instr_reg <= NOP_INSTR;
        id_pc_reg <= '0;
        valid_reg <= 1'b0;
      end else if (advance) begin
        instr_reg <= imem_rdata;
        id_pc_reg <= pc_reg;
        valid_reg <= 1'b1;
        count_reg <= count_reg + 32'd1;
      end
    end
  end

  assign imem_addr    = pc_reg;
  assign if_id_instr  = instr_reg;
  assign if_id_pc     = id_pc_reg;
  assign if_id_valid  = valid_reg;
  assign misalign_err = misalign_reg;
  assign fetch_count  = count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// stall/redirect/reset traffic compared every cycle against a behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc, fetch_count;
  logic        if_id_valid, misalign_err;
  logic [31:0] imem_addr_w, imem_rdata_w, if_id_instr_w, if_id_pc_w, fetch_count_w;
  logic        if_id_valid_w, misalign_err_w;

  logic [31:0] mem [0:63];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
  logic        m_valid, m_mis, m_just_reset;

  always #5 clk = ~clk;

  assign imem_rdata   = mem[imem_addr[7:2]];
  assign imem_rdata_w = mem[imem_addr_w[7:2]];

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
    .if_id_instr(if_id_instr_w), .if_id_pc(if_id_pc_w), .if_id_valid(if_id_valid_w),
    .misalign_err(misalign_err_w), .fetch_count(fetch_count_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the first cycle after reset never fetches; otherwise redirect
  // flushes, stall holds, and anything else fetches the word at PC.
  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0; m_valid = 1'b0;
      m_mis = 1'b0; m_cnt = 32'h0; m_just_reset = 1'b1;
    end else begin
      if (redirect) begin
        if (redirect_pc % 4 != 0) m_mis = 1'b1;
        m_instr = NOP; m_ipc = 32'h0; m_valid = 1'b0;
        m_pc = redirect_pc - (redirect_pc % 4);
      end else if (!m_just_reset && !stall) begin
        m_instr = mem[(m_pc / 4) % 64];
        m_ipc   = m_pc;
        m_valid = 1'b1;
        m_cnt   = m_cnt + 1;
        m_pc    = m_pc + 4;
      end
      m_just_reset = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_addr", imem_addr, m_pc);
      check("if_id_instr", if_id_instr, m_instr);
      check("if_id_pc", if_id_pc, m_ipc);
      check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
      check("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
      check("fetch_count", fetch_count, m_cnt);
      $display("cyc rst=%0b stall=%0b redir=%0b rpc=%h | addr=%h instr=%h pc=%h v=%0b mis=%0b cnt=%0d",
               rst, stall, redirect, redirect_pc, imem_addr, if_id_instr, if_id_pc,
               if_id_valid, misalign_err, fetch_count);
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0000_0013;
    mem[2] = 32'h00A0_0113;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    @(negedge clk); @(negedge clk);
    chk_en = 1'b1;
    check("rst_instr", if_id_instr, NOP);
    check("rst_addr", imem_addr, 32'h0);
    @(negedge clk);
    check("rst_hold_valid", {31'b0, if_id_valid}, 32'h0);
    check("rst_hold_cnt", fetch_count, 32'h0);

    // Reset release and three sequential fetches
    rst = 1'b0;
    @(negedge clk);
    check("c1_valid", {31'b0, if_id_valid}, 32'h0);
    check("c1_instr", if_id_instr, NOP);
    @(negedge clk);
    check("c2_pc", if_id_pc, 32'h0);
    check("c2_instr", if_id_instr, 32'h0050_0093);
    check("c2_valid", {31'b0, if_id_valid}, 32'h1);
    @(negedge clk);
    check("c3_pc", if_id_pc, 32'h4);
    check("c3_instr", if_id_instr, 32'h0000_0013);
    @(negedge clk);
    check("c4_pc", if_id_pc, 32'h8);
    check("c4_instr", if_id_instr, 32'h00A0_0113);
    check("c4_count", fetch_count, 32'd3);
    check("c4_addr", imem_addr, 32'hC);

    // Back to PC=8, then stall three cycles
    redirect = 1'b1; redirect_pc = 32'h8;
    @(negedge clk);
    check("redir8_addr", imem_addr, 32'h8);
    redirect = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_addr", imem_addr, 32'h8);
      check("stall_valid", {31'b0, if_id_valid}, 32'h0);
    end
    stall = 1'b0;
    @(negedge clk);
    check("resume_pc8", if_id_pc, 32'h8);
    check("resume_cnt", fetch_count, 32'd4);
    @(negedge clk);
    check("resume_pc12", if_id_pc, 32'hC);

    // Redirect wins over a concurrent stall
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    check("rs_addr", imem_addr, 32'h40);
    check("rs_valid", {31'b0, if_id_valid}, 32'h0);
    check("rs_instr", if_id_instr, NOP);
    check("rs_cnt", fetch_count, 32'd5);
    stall = 1'b0; redirect = 1'b0;
    @(negedge clk);
    check("rs_next_pc", if_id_pc, 32'h40);

    // Misaligned target
    redirect = 1'b1; redirect_pc = 32'h42;
    @(negedge clk);
    check("mis_addr", imem_addr, 32'h40);
    check("mis_flag", {31'b0, misalign_err}, 32'h1);
    redirect = 1'b0;
    repeat (5) @(negedge clk);
    check("mis_sticky", {31'b0, misalign_err}, 32'h1);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      stall    = ($urandom_range(0, 9) < 3);
      redirect = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 7))
        0:       redirect_pc = 32'hFFFF_FFF0;
        1:       redirect_pc = {24'h0, 6'($urandom), 2'($urandom)};
        default: redirect_pc = {24'h0, 6'($urandom), 2'b00};
      endcase
      @(negedge clk);
    end

    // Reset during a stall with a coincident redirect
    rst = 1'b0; stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h42;
    @(negedge clk);
    redirect = 1'b0; stall = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; redirect = 1'b1; redirect_pc = 32'h84;
    @(negedge clk);
    check("rsr_addr", imem_addr, 32'h0);
    check("rsr_instr", if_id_instr, NOP);
    check("rsr_pc", if_id_pc, 32'h0);
    check("rsr_valid", {31'b0, if_id_valid}, 32'h0);
    check("rsr_mis", {31'b0, misalign_err}, 32'h0);
    check("rsr_cnt", fetch_count, 32'h0);
    @(negedge clk);
    check("rsr_hold_addr", imem_addr, 32'h0);

    // PC wrap on the instance reset to 0xFFFF_FFF8
    rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    @(negedge clk);
    check("wrap_idle_valid", {31'b0, if_id_valid_w}, 32'h0);
    @(negedge clk);
    check("wrap_pc0", if_id_pc_w, 32'hFFFF_FFF8);
    @(negedge clk);
    check("wrap_pc1", if_id_pc_w, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_pc2", if_id_pc_w, 32'h0000_0000);
    check("wrap_cnt", fetch_count_w, 32'd3);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
